// File: rtl/ex_wb_stage.sv
// Execute/write-back stage: ALU write-back, load completion, flag update, branch redirect and squash.
// Latency: ALU write-back and redirect 1 cycle after acceptance, load write-back 2 cycles after acceptance.
// Backpressure: in_ready drops for exactly one cycle while a live load waits for readData.
module ex_wb_stage (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        regWrite,
    input  logic        memRead,
    input  logic        memToReg,
    input  logic        updFlags,
    input  logic        jump,
    input  logic        branchZ,
    input  logic        branchN,
    input  logic [5:0]  rdAddr,
    input  logic [31:0] result,
    input  logic [31:0] readData,
    input  logic [31:0] target,
    input  logic        zero,
    input  logic        neg,
    output logic        wbEn,
    output logic [5:0]  wbAddr,
    output logic [31:0] wbData,
    output logic        pcSrc,
    output logic [31:0] pcTarget,
    output logic        flush
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  flush_cnt;
    logic        flag_z;
    logic        flag_n;
    logic        hold_we;
    logic        hold_m2r;
    logic [5:0]  hold_rd;
    logic [31:0] hold_res;
    logic        xfer;
    logic        taken;

    assign xfer  = in_valid & in_ready;
    // Branches see the flags as they stood before this instruction's own update.
    assign taken = jump | (branchZ & flag_z) | (branchN & flag_n);
    assign flush = (flush_cnt != 2'd0);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ready; a load only stalls when it is live (not being squashed).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && (flush_cnt == 2'd0) && memRead) begin
                    state_nxt = MEMWAIT;
                end
            end
            MEMWAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: write-back, held load context, flags, redirect and squash counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wbEn      <= 1'b0;
            wbAddr    <= 6'd0;
            wbData    <= 32'd0;
            pcSrc     <= 1'b0;
            pcTarget  <= 32'd0;
            flush_cnt <= 2'd0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            hold_we   <= 1'b0;
            hold_m2r  <= 1'b0;
            hold_rd   <= 6'd0;
            hold_res  <= 32'd0;
        end else begin
            wbEn  <= 1'b0;
            pcSrc <= 1'b0;
            if (state == MEMWAIT) begin
                if (hold_we) begin
                    wbEn   <= 1'b1;
                    wbAddr <= hold_rd;
                    wbData <= hold_m2r ? readData : hold_res;
                end
            end else if (xfer) begin
                if (flush_cnt != 2'd0) begin
                    flush_cnt <= flush_cnt - 2'd1;
                end else begin
                    if (taken) begin
                        pcSrc     <= 1'b1;
                        pcTarget  <= target;
                        flush_cnt <= 2'd2;
                    end
                    if (updFlags) begin
                        flag_z <= zero;
                        flag_n <= neg;
                    end
                    if (memRead) begin
                        hold_we  <= regWrite;
                        hold_m2r <= memToReg;
                        hold_rd  <= rdAddr;
                        hold_res <= result;
                    end else if (regWrite) begin
                        wbEn   <= 1'b1;
                        wbAddr <= rdAddr;
                        wbData <= result;
                    end
                end
            end
        end
    end

endmodule
